dmem_port_arbiter: RTL and testbench

Arbiter and sequencer for the single data-memory port of the out-of-order core. Shares the port between the load unit (speculative, tagged loads) and the commit-side store path (retired stores). Issues at most one memory operation per cycle and returns load data with its tag one cycle later. Bounds store starvation with a wait counter. Sits between the LSQ/commit logic and the `datamem` port (`addressLoad` / `addressStore` / `read_enable` / `write_enable`).

---
 rtl/dmem_port_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_dmem_port_arbiter.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_port_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_port_arbiter
//
// Shares the single data-memory port between the speculative load unit and
// the retired-store path. At most one memory operation is issued per cycle.
// Load data comes back with its tag one cycle after the load is accepted.
// A wait counter bounds how long a pending store can lose to loads.
//
// Optional feature macro: DMEM_ARB_STBUF_EN
//   When defined, a 1-entry store buffer decouples store acceptance from the
//   port. Loads that hit the buffered address are answered from the buffer.
//
// Ports:
//   clk, reset_n                 clock (rising edge), async active-low reset
//   ld_valid_i/ld_ready_o        load request handshake
//   ld_addr_i, ld_tag_i          load address and tag
//   ld_resp_valid_o/_tag_o/_data_o  load response, one cycle after accept
//   st_valid_i/st_ready_o        retired store handshake
//   st_addr_i, st_data_i         store address and data
//   flush_i                      pipeline squash, kills speculative loads
//   dmem_addressLoad/_Store      memory read / write addresses
//   dmem_WriteData               memory write data
//   dmem_readEn/_writeEn         memory strobes (never both high)
//   dmem_readData                memory read data, valid cycle after readEn
// ---------------------------------------------------------------------------
module dmem_port_arbiter #(
   parameter int ADDR_W     = 64,
   parameter int DATA_W     = 64,
   parameter int TAG_W      = 6,
   parameter int STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              ld_valid_i,
   output logic              ld_ready_o,
   input  logic [ADDR_W-1:0] ld_addr_i,
   input  logic [TAG_W-1:0]  ld_tag_i,
   output logic              ld_resp_valid_o,
   output logic [TAG_W-1:0]  ld_resp_tag_o,
   output logic [DATA_W-1:0] ld_resp_data_o,
   input  logic              st_valid_i,
   output logic              st_ready_o,
   input  logic [ADDR_W-1:0] st_addr_i,
   input  logic [DATA_W-1:0] st_data_i,
   input  logic              flush_i,
   output logic [ADDR_W-1:0] dmem_addressLoad,
   output logic [ADDR_W-1:0] dmem_addressStore,
   output logic [DATA_W-1:0] dmem_WriteData,
   output logic              dmem_readEn,
   output logic              dmem_writeEn,
   input  logic [DATA_W-1:0] dmem_readData
);

   typedef enum logic {IDLE, LD_PEND} state_t;

   localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

   state_t            r_state;
   logic [3:0]        r_starveCnt;
   logic [TAG_W-1:0]  r_respTag;
   logic [ADDR_W-1:0] r_ldAddr;
   logic [ADDR_W-1:0] r_stAddr;
   logic [DATA_W-1:0] r_stData;

   logic              w_ldReq;
   logic              w_stReq;
   logic              w_ldHit;
   logic              w_ldGrant;
   logic              w_stGrant;
   logic              w_rdEn;
   logic [ADDR_W-1:0] w_stAddr;
   logic [DATA_W-1:0] w_stData;

`ifdef DMEM_ARB_STBUF_EN
   logic              r_bufValid;
   logic [ADDR_W-1:0] r_bufAddr;
   logic [DATA_W-1:0] r_bufData;
   logic              r_respFromBuf;
   logic [DATA_W-1:0] r_respData;
`endif

   // Request qualification. Requests are masked while reset is asserted so
   // the strobes and ready outputs stay low during reset. With the store
   // buffer, the store side competing for the port is the buffer entry, and
   // a load hitting that entry is served from it while the port drains it.
   always_comb begin
      w_ldReq = reset_n & ld_valid_i & ~flush_i;
`ifdef DMEM_ARB_STBUF_EN
      w_stReq  = reset_n & r_bufValid;
      w_stAddr = r_bufAddr;
      w_stData = r_bufData;
      w_ldHit  = w_ldReq & r_bufValid & (ld_addr_i == r_bufAddr);
`else
      w_stReq  = reset_n & st_valid_i;
      w_stAddr = st_addr_i;
      w_stData = st_data_i;
      w_ldHit  = 1'b0;
`endif
   end

   // Grant: a lone requester wins; when both want the port the load wins
   // unless the store has already lost STARVE_MAX times in a row. A buffer
   // hit grants both, since the load then needs no read strobe.
   always_comb begin
      w_stGrant = w_stReq & (~w_ldReq | w_ldHit | (r_starveCnt == STARVE_LIM));
      w_ldGrant = w_ldReq & (~w_stGrant | w_ldHit);
      w_rdEn    = w_ldGrant & ~w_ldHit;
   end

   // Port outputs: addresses and data follow the granted request and hold
   // their last issued value otherwise.
   assign ld_ready_o        = w_ldGrant;
   assign dmem_readEn       = w_rdEn;
   assign dmem_writeEn      = w_stGrant;
   assign dmem_addressLoad  = w_rdEn    ? ld_addr_i : r_ldAddr;
   assign dmem_addressStore = w_stGrant ? w_stAddr  : r_stAddr;
   assign dmem_WriteData    = w_stGrant ? w_stData  : r_stData;

   // A flush in the response cycle squashes the returning load.
   assign ld_resp_valid_o = (r_state == LD_PEND) & ~flush_i;
   assign ld_resp_tag_o   = r_respTag;

`ifdef DMEM_ARB_STBUF_EN
   assign st_ready_o     = reset_n & (~r_bufValid | w_stGrant);
   assign ld_resp_data_o = (r_state == LD_PEND) ?
                           (r_respFromBuf ? r_respData : dmem_readData) : '0;
`else
   assign st_ready_o     = w_stGrant;
   assign ld_resp_data_o = (r_state == LD_PEND) ? dmem_readData : '0;
`endif

   // Sequencer: tracks the outstanding load, captures its tag, keeps the
   // held port values and counts consecutive store losses (saturating).
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= IDLE;
         r_starveCnt <= '0;
         r_respTag   <= '0;
         r_ldAddr    <= '0;
         r_stAddr    <= '0;
         r_stData    <= '0;
      end else begin
         r_state <= w_ldGrant ? LD_PEND : IDLE;
         if (w_ldGrant)
            r_respTag <= ld_tag_i;
         if (w_rdEn)
            r_ldAddr <= ld_addr_i;
         if (w_stGrant) begin
            r_stAddr <= w_stAddr;
            r_stData <= w_stData;
         end
         if (w_stReq && w_ldGrant && !w_stGrant) begin
            if (r_starveCnt != STARVE_LIM)
               r_starveCnt <= r_starveCnt + 4'd1;
         end else begin
            r_starveCnt <= '0;
         end
      end
   end

`ifdef DMEM_ARB_STBUF_EN
   // Store buffer: drains on a store grant and refills from a new accepted
   // store in the same cycle. Flush never touches it because buffered
   // stores are already retired.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_bufValid    <= 1'b0;
         r_bufAddr     <= '0;
         r_bufData     <= '0;
         r_respFromBuf <= 1'b0;
         r_respData    <= '0;
      end else begin
         if (w_stGrant)
            r_bufValid <= 1'b0;
         if (st_valid_i && st_ready_o) begin
            r_bufValid <= 1'b1;
            r_bufAddr  <= st_addr_i;
            r_bufData  <= st_data_i;
         end
         r_respFromBuf <= w_ldHit;
         if (w_ldHit)
            r_respData <= r_bufData;
      end
   end
`endif

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dmem_port_arbiter
//
// Directed bench for dmem_port_arbiter with a small behavioural data memory
// attached to the dmem_* port (synchronous write, registered read).
// Initial memory contents: word at byte address A holds 64'hC0DE_0000_0000_0000 + A.
// ---------------------------------------------------------------------------
module tb_dmem_port_arbiter;

   logic        clk;
   logic        reset_n;
   logic        ld_valid_i;
   logic        ld_ready_o;
   logic [63:0] ld_addr_i;
   logic [5:0]  ld_tag_i;
   logic        ld_resp_valid_o;
   logic [5:0]  ld_resp_tag_o;
   logic [63:0] ld_resp_data_o;
   logic        st_valid_i;
   logic        st_ready_o;
   logic [63:0] st_addr_i;
   logic [63:0] st_data_i;
   logic        flush_i;
   logic [63:0] dmem_addressLoad;
   logic [63:0] dmem_addressStore;
   logic [63:0] dmem_WriteData;
   logic        dmem_readEn;
   logic        dmem_writeEn;
   logic [63:0] dmem_readData;

   logic [63:0] mem [0:255];

   int errors = 0;
   int checks = 0;

   dmem_port_arbiter #(
      .ADDR_W(64), .DATA_W(64), .TAG_W(6), .STARVE_MAX(4)
   ) dut (
      .clk               (clk),
      .reset_n           (reset_n),
      .ld_valid_i        (ld_valid_i),
      .ld_ready_o        (ld_ready_o),
      .ld_addr_i         (ld_addr_i),
      .ld_tag_i          (ld_tag_i),
      .ld_resp_valid_o   (ld_resp_valid_o),
      .ld_resp_tag_o     (ld_resp_tag_o),
      .ld_resp_data_o    (ld_resp_data_o),
      .st_valid_i        (st_valid_i),
      .st_ready_o        (st_ready_o),
      .st_addr_i         (st_addr_i),
      .st_data_i         (st_data_i),
      .flush_i           (flush_i),
      .dmem_addressLoad  (dmem_addressLoad),
      .dmem_addressStore (dmem_addressStore),
      .dmem_WriteData    (dmem_WriteData),
      .dmem_readEn       (dmem_readEn),
      .dmem_writeEn      (dmem_writeEn),
      .dmem_readData     (dmem_readData)
   );

   // Free-running clock, 10 time-unit period.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Data memory model: write lands at the clock edge ending the write cycle,
   // read data appears the cycle after the read strobe.
   always @(posedge clk) begin
      if (dmem_writeEn)
         mem[dmem_addressStore[10:3]] <= dmem_WriteData;
      if (dmem_readEn)
         dmem_readData <= mem[dmem_addressLoad[10:3]];
   end

   // Drive one cycle of inputs just after the rising edge, then let the
   // combinational outputs settle before checks.
   task automatic applyStimulus(input logic ldv, input logic [63:0] lda,
                                input logic [5:0] ldt, input logic stv,
                                input logic [63:0] sta, input logic [63:0] std,
                                input logic fl);
      @(posedge clk);
      #1;
      ld_valid_i = ldv;
      ld_addr_i  = lda;
      ld_tag_i   = ldt;
      st_valid_i = stv;
      st_addr_i  = sta;
      st_data_i  = std;
      flush_i    = fl;
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Directed sequence: reset, back-to-back loads, store/load forwarding
   // through memory, flush, starvation pattern, reset during a pending load.
   initial begin
      for (int i = 0; i < 256; i++)
         mem[i] = 64'hC0DE_0000_0000_0000 + 64'(i * 8);
      dmem_readData = '0;
      reset_n    = 1'b0;
      ld_valid_i = 1'b0;
      ld_addr_i  = '0;
      ld_tag_i   = '0;
      st_valid_i = 1'b0;
      st_addr_i  = '0;
      st_data_i  = '0;
      flush_i    = 1'b0;

      #2;
      checkOutput("rst_resp_valid", 64'(ld_resp_valid_o), 64'd0);
      checkOutput("rst_resp_tag",   64'(ld_resp_tag_o),   64'd0);
      checkOutput("rst_resp_data",  ld_resp_data_o,       64'd0);
      checkOutput("rst_addr_load",  dmem_addressLoad,     64'd0);
      checkOutput("rst_addr_store", dmem_addressStore,    64'd0);
      ld_valid_i = 1'b1;
      st_valid_i = 1'b1;
      #1;
      checkOutput("rst_readEn",  64'(dmem_readEn),  64'd0);
      checkOutput("rst_writeEn", 64'(dmem_writeEn), 64'd0);
      checkOutput("rst_ld_ready", 64'(ld_ready_o),  64'd0);
      ld_valid_i = 1'b0;
      st_valid_i = 1'b0;
      @(posedge clk);
      #1;
      reset_n = 1'b1;

      $display("[TB] back-to-back loads");
      applyStimulus(1, 64'h8, 6'd1, 0, 64'h0, 64'h0, 0);
      checkOutput("b2b_ready0",  64'(ld_ready_o),  64'd1);
      checkOutput("b2b_readEn0", 64'(dmem_readEn), 64'd1);
      checkOutput("b2b_addr0",   dmem_addressLoad, 64'h8);
      applyStimulus(1, 64'h10, 6'd2, 0, 64'h0, 64'h0, 0);
      checkOutput("b2b_valid1", 64'(ld_resp_valid_o), 64'd1);
      checkOutput("b2b_tag1",   64'(ld_resp_tag_o),   64'd1);
      checkOutput("b2b_data1",  ld_resp_data_o,       64'hC0DE_0000_0000_0008);
      checkOutput("b2b_addr1",  dmem_addressLoad,     64'h10);
      applyStimulus(1, 64'h18, 6'd3, 0, 64'h0, 64'h0, 0);
      checkOutput("b2b_tag2",  64'(ld_resp_tag_o), 64'd2);
      checkOutput("b2b_data2", ld_resp_data_o,     64'hC0DE_0000_0000_0010);
      applyStimulus(0, 64'h0, 6'd0, 0, 64'h0, 64'h0, 0);
      checkOutput("b2b_valid3",  64'(ld_resp_valid_o), 64'd1);
      checkOutput("b2b_tag3",    64'(ld_resp_tag_o),   64'd3);
      checkOutput("b2b_data3",   ld_resp_data_o,       64'hC0DE_0000_0000_0018);
      checkOutput("b2b_idle_rd", 64'(dmem_readEn),     64'd0);
      checkOutput("b2b_hold",    dmem_addressLoad,     64'h18);
      applyStimulus(0, 64'h0, 6'd0, 0, 64'h0, 64'h0, 0);
      checkOutput("b2b_done", 64'(ld_resp_valid_o), 64'd0);

`ifndef DMEM_ARB_STBUF_EN
      $display("[TB] store then load");
      applyStimulus(0, 64'h0, 6'd0, 1, 64'h20, 64'hDEAD_BEEF, 0);
      checkOutput("st_ready",   64'(st_ready_o),   64'd1);
      checkOutput("st_writeEn", 64'(dmem_writeEn), 64'd1);
      checkOutput("st_readEn",  64'(dmem_readEn),  64'd0);
      checkOutput("st_addr",    dmem_addressStore, 64'h20);
      checkOutput("st_wdata",   dmem_WriteData,    64'hDEAD_BEEF);
      applyStimulus(1, 64'h20, 6'd4, 0, 64'h0, 64'h0, 0);
      checkOutput("sl_ready",   64'(ld_ready_o),   64'd1);
      checkOutput("sl_writeEn", 64'(dmem_writeEn), 64'd0);
      applyStimulus(0, 64'h0, 6'd0, 0, 64'h0, 64'h0, 0);
      checkOutput("sl_valid", 64'(ld_resp_valid_o), 64'd1);
      checkOutput("sl_tag",   64'(ld_resp_tag_o),   64'd4);
      checkOutput("sl_data",  ld_resp_data_o,       64'hDEAD_BEEF);

      $display("[TB] flush");
      applyStimulus(1, 64'h30, 6'd7, 0, 64'h0, 64'h0, 0);
      checkOutput("fl_accept", 64'(ld_ready_o), 64'd1);
      applyStimulus(1, 64'h8, 6'd8, 1, 64'h38, 64'h55, 1);
      checkOutput("fl_valid",   64'(ld_resp_valid_o), 64'd0);
      checkOutput("fl_ld_rdy",  64'(ld_ready_o),      64'd0);
      checkOutput("fl_readEn",  64'(dmem_readEn),     64'd0);
      checkOutput("fl_st_rdy",  64'(st_ready_o),      64'd1);
      checkOutput("fl_writeEn", 64'(dmem_writeEn),    64'd1);
      applyStimulus(0, 64'h0, 6'd0, 0, 64'h0, 64'h0, 0);
      checkOutput("fl_after", 64'(ld_resp_valid_o), 64'd0);
      checkOutput("fl_mem",   mem[7],               64'h55);

      $display("[TB] starvation");
      begin
         logic [9:0] expSt;
         expSt = 10'b10_0001_0000;
         for (int i = 0; i < 10; i++) begin
            applyStimulus(1, 64'h8, 6'(i), 1, 64'h48, 64'h77, 0);
            checkOutput($sformatf("stv_st_%0d", i), 64'(st_ready_o), 64'(expSt[i]));
            checkOutput($sformatf("stv_ld_%0d", i), 64'(ld_ready_o), 64'(!expSt[i]));
         end
      end
      applyStimulus(0, 64'h0, 6'd0, 0, 64'h0, 64'h0, 0);
      checkOutput("stv_mem", mem[9], 64'h77);
`else
      $display("[TB] store buffer");
      applyStimulus(1, 64'h8, 6'd10, 1, 64'h40, 64'h1234, 0);
      checkOutput("sb_st_rdy",  64'(st_ready_o),   64'd1);
      checkOutput("sb_ld_rdy",  64'(ld_ready_o),   64'd1);
      checkOutput("sb_readEn",  64'(dmem_readEn),  64'd1);
      checkOutput("sb_writeEn", 64'(dmem_writeEn), 64'd0);
      applyStimulus(1, 64'h10, 6'd11, 0, 64'h0, 64'h0, 0);
      checkOutput("sb_ld2_rdy", 64'(ld_ready_o),   64'd1);
      checkOutput("sb_wr2",     64'(dmem_writeEn), 64'd0);
      checkOutput("sb_tag10",   64'(ld_resp_tag_o), 64'd10);
      applyStimulus(1, 64'h40, 6'd12, 0, 64'h0, 64'h0, 0);
      checkOutput("sb_hit_rdy",  64'(ld_ready_o),   64'd1);
      checkOutput("sb_hit_rd",   64'(dmem_readEn),  64'd0);
      checkOutput("sb_drain_wr", 64'(dmem_writeEn), 64'd1);
      checkOutput("sb_drain_a",  dmem_addressStore, 64'h40);
      checkOutput("sb_drain_d",  dmem_WriteData,    64'h1234);
      checkOutput("sb_tag11",    64'(ld_resp_tag_o), 64'd11);
      applyStimulus(0, 64'h0, 6'd0, 0, 64'h0, 64'h0, 0);
      checkOutput("sb_hit_valid", 64'(ld_resp_valid_o), 64'd1);
      checkOutput("sb_hit_tag",   64'(ld_resp_tag_o),   64'd12);
      checkOutput("sb_hit_data",  ld_resp_data_o,       64'h1234);
      checkOutput("sb_empty_wr",  64'(dmem_writeEn),    64'd0);
      checkOutput("sb_mem",       mem[8],               64'h1234);
`endif

      $display("[TB] reset during pending load");
      applyStimulus(1, 64'h10, 6'd5, 0, 64'h0, 64'h0, 0);
      checkOutput("rml_accept", 64'(ld_ready_o), 64'd1);
      applyStimulus(1, 64'h18, 6'd6, 0, 64'h0, 64'h0, 0);
      checkOutput("rml_valid", 64'(ld_resp_valid_o), 64'd1);
      checkOutput("rml_tag",   64'(ld_resp_tag_o),   64'd5);
      reset_n = 1'b0;
      #1;
      checkOutput("rml_drop",    64'(ld_resp_valid_o), 64'd0);
      checkOutput("rml_tag0",    64'(ld_resp_tag_o),   64'd0);
      checkOutput("rml_readEn",  64'(dmem_readEn),     64'd0);
      checkOutput("rml_writeEn", 64'(dmem_writeEn),    64'd0);
      applyStimulus(0, 64'h0, 6'd0, 0, 64'h0, 64'h0, 0);
      reset_n = 1'b1;
      applyStimulus(0, 64'h0, 6'd0, 0, 64'h0, 64'h0, 0);
      checkOutput("rml_no_resp", 64'(ld_resp_valid_o), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
